pci_bus_arbiter: RTL and testbench

- Central PCI arbiter: the other end of every device controller's req/gnt handshake.
- Receives one request line per device and issues at most one grant at a time, using round-robin fairness.
- Watches frame and irdy to detect bus idle, supports hidden arbitration, parks the bus on a default master, and revokes a grant that is not used within a timeout.
- Sits at top level beside the four device controllers (2-bit device address space).

---
 rtl/pci_pkg.sv | 35 +++
 rtl/pci_bus_arbiter_if.sv | 45 ++++
 rtl/pci_rr_select.sv | 41 ++++
 rtl/pci_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pci_pkg.sv
// -----------------------------------------------------------------------------
// pci_pkg
// Shared definitions for the central PCI arbiter and the device controllers
// that sit beside it on the bus.
//   - arb_state_t : arbiter state encoding (PARK, SWITCH, GRANT, OWNED)
//   - ASSERTED / DEASSERTED : levels of the active-low PCI control lines
//   - owner_t     : device index (2-bit device address space)
//   - onehot()    : device index to a one-hot select vector
// -----------------------------------------------------------------------------
package pci_pkg;

   localparam int OWNER_W     = 2;
   localparam int MAX_MASTERS = 4;

   // All PCI control lines seen by the arbiter are active-low.
   localparam logic ASSERTED   = 1'b0;
   localparam logic DEASSERTED = 1'b1;

   typedef logic [OWNER_W-1:0] owner_t;

   typedef enum logic [1:0] {
      PARK   = 2'd0,  // bus parked on the default master, nobody requesting
      SWITCH = 2'd1,  // one dead cycle with every gnt high
      GRANT  = 2'd2,  // owner granted, its transaction has not started
      OWNED  = 2'd3   // owner is mastering a transaction
   } arb_state_t;

   function automatic logic [MAX_MASTERS-1:0] onehot(owner_t idx);
      logic [MAX_MASTERS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/pci_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// pci_bus_arbiter_if
// Arbitration signals between the central arbiter and the device controllers.
//   req         : active-low request, one bit per device (devices drive)
//   frame, irdy : PCI frame / irdy, active-low (observed by the arbiter)
//   gnt         : active-low grants, at most one low (arbiter drives)
//   owner       : index of the device granted or parked (arbiter drives)
//   owner_valid : high while some gnt bit is low (arbiter drives)
// Handshake: a device pulls its req low and holds it until it no longer wants
// the bus; it may start a transaction (frame low) only while its gnt is low
// and the bus was idle (frame and irdy high) on the previous edge.
// Modport master is the arbiter end, modport slave the device end.
// -----------------------------------------------------------------------------
interface pci_bus_arbiter_if
   import pci_pkg::*;
#(
   parameter int N_MASTERS = 4
) ();

   logic [N_MASTERS-1:0] req;
   logic                 frame;
   logic                 irdy;
   logic [N_MASTERS-1:0] gnt;
   owner_t               owner;
   logic                 owner_valid;

   modport master (
      input  req,
      input  frame,
      input  irdy,
      output gnt,
      output owner,
      output owner_valid
   );

   modport slave (
      output req,
      output frame,
      output irdy,
      input  gnt,
      input  owner,
      input  owner_valid
   );

endinterface

// File: rtl/pci_rr_select.sv
// -----------------------------------------------------------------------------
// pci_rr_select
// Combinational round-robin pick. Scans from (last_owner+1) mod N_MASTERS
// upward with wrap and returns the first device with req asserted (low) that
// is not masked off by exclude.
//   req        : active-low requests, unused upper bits must be high
//   last_owner : device that most recently received a grant
//   exclude    : active-high mask of devices to skip
//   winner     : selected device (holds last_owner when nothing qualifies)
//   any_req    : high when some device qualified
// -----------------------------------------------------------------------------
module pci_rr_select
   import pci_pkg::*;
#(
   parameter int N_MASTERS = 4
) (
   input  logic [MAX_MASTERS-1:0] req,
   input  owner_t                 last_owner,
   input  logic [MAX_MASTERS-1:0] exclude,
   output owner_t                 winner,
   output logic                   any_req
);

   owner_t pos;

   // Walk the scan order backwards so the device closest to last_owner+1
   // is the last to write winner and therefore takes priority.
   always_comb begin
      winner  = last_owner;
      any_req = 1'b0;
      pos     = '0;
      for (int i = N_MASTERS; i >= 1; i--) begin
         pos = owner_t'((int'(last_owner) + i) % N_MASTERS);
         if (req[pos] == ASSERTED && !exclude[pos]) begin
            winner  = pos;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pci_bus_arbiter.sv
// -----------------------------------------------------------------------------
// pci_bus_arbiter
// Central PCI arbiter: round-robin grants, bus parking on PARK_MASTER, hidden
// arbitration during a running transaction, and revocation of a grant that
// is not used within GNT_TIMEOUT idle-bus cycles.
//   clk   : bus clock, rising edge
//   rst   : asynchronous reset, active-high
//   bus   : arbitration interface (req, frame, irdy in; gnt, owner,
//           owner_valid out), all outputs registered
//   state : current arbiter state, for observation
// Every change of grant passes through SWITCH, a cycle with all gnt high, so
// two gnt bits are never low together.
// -----------------------------------------------------------------------------
module pci_bus_arbiter
   import pci_pkg::*;
#(
   parameter int N_MASTERS   = 4,
   parameter int PARK_MASTER = 0,
   parameter int GNT_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   pci_bus_arbiter_if.master bus,
   output arb_state_t        state
);

   localparam int               CNT_W     = $clog2(GNT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(GNT_TIMEOUT);
   localparam owner_t           PARK_IDX  = owner_t'(PARK_MASTER);
   localparam owner_t           LAST_INIT = owner_t'(N_MASTERS - 1);

   arb_state_t           state_q, state_d;
   owner_t               target_q, target_d;   // device to grant after SWITCH
   owner_t               owner_q, owner_d;
   owner_t               last_q, last_d;       // round-robin pointer
   logic [N_MASTERS-1:0] gnt_q, gnt_d;
   logic                 valid_q, valid_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 prev_idle_q;          // bus was idle at previous edge

   logic [MAX_MASTERS-1:0] req_all;
   logic [MAX_MASTERS-1:0] owner_mask;
   logic [MAX_MASTERS-1:0] issue_vec;
   logic                   bus_idle;
   owner_t                 win_all, win_other;
   logic                   any_all, any_other;
   logic                   do_switch;
   owner_t                 switch_to;

   // Devices beyond N_MASTERS never request.
   always_comb begin
      req_all                = '1;
      req_all[N_MASTERS-1:0] = bus.req;
   end

   assign bus_idle   = (bus.frame == DEASSERTED) && (bus.irdy == DEASSERTED);
   assign owner_mask = onehot(owner_q);
   assign issue_vec  = ~onehot(target_q);

   pci_rr_select #(.N_MASTERS(N_MASTERS)) u_pick_all (
      .req        (req_all),
      .last_owner (last_q),
      .exclude    ('0),
      .winner     (win_all),
      .any_req    (any_all)
   );

   // Same scan with the current owner masked off: used for hidden arbitration
   // and for handing the bus on after a timeout.
   pci_rr_select #(.N_MASTERS(N_MASTERS)) u_pick_other (
      .req        (req_all),
      .last_owner (last_q),
      .exclude    (owner_mask),
      .winner     (win_other),
      .any_req    (any_other)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SWITCH;
         target_q    <= PARK_IDX;
         owner_q     <= PARK_IDX;
         last_q      <= LAST_INIT;
         gnt_q       <= '1;
         valid_q     <= 1'b0;
         cnt_q       <= '0;
         prev_idle_q <= 1'b0;  // ignore frame until the bus is seen idle
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         valid_q     <= valid_d;
         cnt_q       <= cnt_d;
         prev_idle_q <= bus_idle;
      end
   end

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      owner_d   = owner_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
      do_switch = 1'b0;
      switch_to = PARK_IDX;

      case (state_q)
         PARK: begin
            if (any_all) begin
               if (win_all == PARK_IDX) begin
                  // Parked master already holds gnt: no dead cycle needed.
                  state_d = GRANT;
                  cnt_d   = '0;
               end else begin
                  do_switch = 1'b1;
                  switch_to = win_all;
               end
            end
         end

         SWITCH: begin
            gnt_d   = issue_vec[N_MASTERS-1:0];
            owner_d = target_q;
            valid_d = 1'b1;
            last_d  = target_q;
            if (target_q == PARK_IDX && !any_all) begin
               state_d = PARK;
            end else begin
               state_d = GRANT;
               cnt_d   = '0;
            end
         end

         GRANT: begin
            if (bus.frame == ASSERTED && prev_idle_q) begin
               state_d = OWNED;
            end else if (req_all[owner_q] == DEASSERTED) begin
               do_switch = 1'b1;
               switch_to = any_all ? win_all : PARK_IDX;
            end else if (cnt_q == CNT_MAX) begin
               do_switch = 1'b1;
               switch_to = any_other ? win_other : PARK_IDX;
            end else if (bus_idle) begin
               // Leaving GRANT at CNT_MAX makes this increment saturating.
               cnt_d = cnt_q + 1'b1;
            end
         end

         OWNED: begin
            if (any_other) begin
               // Hidden arbitration: the owner keeps frame and finishes; the
               // next master waits for bus idle before starting.
               do_switch = 1'b1;
               switch_to = win_other;
            end else if (bus_idle) begin
               if (req_all[owner_q] == DEASSERTED) begin
                  do_switch = 1'b1;
                  switch_to = PARK_IDX;
               end else begin
                  state_d = GRANT;
                  cnt_d   = '0;
               end
            end
         end

         default: begin
            do_switch = 1'b1;
            switch_to = PARK_IDX;
         end
      endcase

      if (do_switch) begin
         state_d  = SWITCH;
         target_d = switch_to;
         owner_d  = switch_to;
         gnt_d    = '1;
         valid_d  = 1'b0;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.owner       = owner_q;
   assign bus.owner_valid = valid_q;
   assign state           = state_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pci_bus_arbiter
// Self-checking bench for pci_bus_arbiter: directed vector table, an
// asynchronous-reset sequence, then randomized traffic against a behavioural
// model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_pci_bus_arbiter;
   import pci_pkg::*;

   localparam int N      = 4;
   localparam int PARK_M = 0;
   localparam int TMO    = 16;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   arb_state_t state;

   pci_bus_arbiter_if #(.N_MASTERS(N)) bus ();

   pci_bus_arbiter #(
      .N_MASTERS   (N),
      .PARK_MASTER (PARK_M),
      .GNT_TIMEOUT (TMO)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .state (state)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int         n_vec = 0;
   int         n_err = 0;
   logic [6:0] exp_q[$];   // {gnt, owner, owner_valid}

   typedef struct {
      logic [3:0] req;
      logic       frame;
      logic       irdy;
      logic [3:0] gnt;
      owner_t     owner;
      logic       valid;
      arb_state_t st;
   } vec_t;

   vec_t vecs[$];

   function automatic void vadd(logic [3:0] r, logic f, logic i, logic [3:0] g,
                                int o, logic v, arb_state_t s);
      vec_t t;
      t.req   = r;
      t.frame = f;
      t.irdy  = i;
      t.gnt   = g;
      t.owner = owner_t'(o);
      t.valid = v;
      t.st    = s;
      vecs.push_back(t);
   endfunction

   // ---------------- checks ----------------
   task automatic check(input string name, input logic [3:0] eg,
                        input owner_t eo, input logic ev);
      n_vec++;
      if (bus.gnt !== eg || bus.owner_valid !== ev || (ev && bus.owner !== eo)) begin
         n_err++;
         $display("FAIL %s: gnt=%b owner=%0d owner_valid=%b, expected gnt=%b owner=%0d owner_valid=%b",
                  name, bus.gnt, bus.owner, bus.owner_valid, eg, eo, ev);
      end
   endtask

   task automatic check_state(input string name, input arb_state_t es);
      n_vec++;
      if (state !== es) begin
         n_err++;
         $display("FAIL %s: state=%0d, expected state=%0d", name, state, es);
      end
   endtask

   // ---------------- driver ----------------
   task automatic apply(input int k);
      @(negedge clk);
      bus.req   = vecs[k].req;
      bus.frame = vecs[k].frame;
      bus.irdy  = vecs[k].irdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].owner, vecs[k].valid);
      check_state($sformatf("vec%0d_state", k), vecs[k].st);
   endtask

   // ---------------- behavioural reference model ----------------
   // holder < 0 means the dead cycle between two grants.
   int m_holder, m_target, m_last, m_wait;
   bit m_parked, m_xfer, m_prev_idle;

   function automatic int rr_pick(logic [3:0] r, int from, int skip);
      for (int k = 1; k <= N; k++) begin
         int d;
         d = (from + k) % N;
         if (r[d[1:0]] == 1'b0 && d != skip) return d;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      m_holder    = -1;
      m_target    = PARK_M;
      m_last      = N - 1;
      m_wait      = 0;
      m_parked    = 1'b0;
      m_xfer      = 1'b0;
      m_prev_idle = 1'b0;
   endfunction

   function automatic void model_edge(logic [3:0] r, logic f, logic i);
      bit idle;
      int w_all, w_oth;
      idle  = f && i;
      w_all = rr_pick(r, m_last, -1);
      w_oth = rr_pick(r, m_last, m_holder);
      if (m_holder < 0) begin
         m_holder = m_target;
         m_parked = (m_target == PARK_M) && (w_all < 0);
         m_xfer   = 1'b0;
         m_wait   = 0;
         m_last   = m_holder;
      end else if (m_parked) begin
         if (w_all == PARK_M) begin
            m_parked = 1'b0;
            m_wait   = 0;
         end else if (w_all >= 0) begin
            m_target = w_all;
            m_holder = -1;
         end
      end else if (!m_xfer) begin
         if (!f && m_prev_idle) begin
            m_xfer = 1'b1;
         end else if (r[m_holder[1:0]]) begin
            m_target = (w_all < 0) ? PARK_M : w_all;
            m_holder = -1;
         end else if (m_wait == TMO) begin
            m_target = (w_oth < 0) ? PARK_M : w_oth;
            m_holder = -1;
         end else if (idle) begin
            m_wait++;
         end
      end else begin
         if (w_oth >= 0) begin
            m_target = w_oth;
            m_holder = -1;
         end else if (idle) begin
            if (r[m_holder[1:0]]) begin
               m_target = PARK_M;
               m_holder = -1;
            end else begin
               m_xfer = 1'b0;
               m_wait = 0;
            end
         end
      end
      m_prev_idle = idle;
   endfunction

   function automatic logic [6:0] model_expect();
      logic [3:0] g;
      g = 4'hF;
      if (m_holder >= 0) g[m_holder[1:0]] = 1'b0;
      return {g, owner_t'(m_holder < 0 ? 0 : m_holder), m_holder >= 0};
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int         split;
      logic [3:0] r;
      logic [6:0] e;

      // idle park
      for (int k = 0; k < 3; k++) vadd(4'b1111, 1, 1, 4'b1110, 0, 1, PARK);
      // single request from device 2, one transaction, release
      vadd(4'b1011, 1, 1, 4'b1111, 2, 0, SWITCH);
      vadd(4'b1011, 1, 1, 4'b1011, 2, 1, GRANT);
      vadd(4'b1011, 0, 0, 4'b1011, 2, 1, OWNED);
      vadd(4'b1111, 1, 1, 4'b1111, 0, 0, SWITCH);
      vadd(4'b1111, 1, 1, 4'b1110, 0, 1, PARK);
      // all requesting, one-cycle transactions: order 1,2,3,0,1
      vadd(4'b0000, 1, 1, 4'b1111, 1, 0, SWITCH);
      vadd(4'b0000, 1, 1, 4'b1101, 1, 1, GRANT);
      vadd(4'b0000, 0, 0, 4'b1101, 1, 1, OWNED);
      vadd(4'b0000, 1, 1, 4'b1111, 2, 0, SWITCH);
      vadd(4'b0000, 1, 1, 4'b1011, 2, 1, GRANT);
      vadd(4'b0000, 0, 0, 4'b1011, 2, 1, OWNED);
      vadd(4'b0000, 1, 1, 4'b1111, 3, 0, SWITCH);
      vadd(4'b0000, 1, 1, 4'b0111, 3, 1, GRANT);
      vadd(4'b0000, 0, 0, 4'b0111, 3, 1, OWNED);
      vadd(4'b0000, 1, 1, 4'b1111, 0, 0, SWITCH);
      vadd(4'b0000, 1, 1, 4'b1110, 0, 1, GRANT);
      vadd(4'b0000, 0, 0, 4'b1110, 0, 1, OWNED);
      vadd(4'b0000, 1, 1, 4'b1111, 1, 0, SWITCH);
      vadd(4'b0000, 1, 1, 4'b1101, 1, 1, GRANT);
      // hidden arbitration: device 1 holds frame 8 cycles, device 3 asks at 2
      vadd(4'b1101, 0, 1, 4'b1101, 1, 1, OWNED);
      vadd(4'b1101, 0, 1, 4'b1101, 1, 1, OWNED);
      vadd(4'b0101, 0, 1, 4'b1111, 3, 0, SWITCH);
      for (int k = 0; k < 5; k++) vadd(4'b0101, 0, 1, 4'b0111, 3, 1, GRANT);
      vadd(4'b0101, 1, 0, 4'b0111, 3, 1, GRANT);
      vadd(4'b0101, 1, 1, 4'b0111, 3, 1, GRANT);
      vadd(4'b0111, 0, 0, 4'b0111, 3, 1, OWNED);
      vadd(4'b0111, 1, 1, 4'b0111, 3, 1, GRANT);
      vadd(4'b1111, 1, 1, 4'b1111, 0, 0, SWITCH);
      vadd(4'b1111, 1, 1, 4'b1110, 0, 1, PARK);
      // unused grant to device 3 is revoked after the timeout
      vadd(4'b0111, 1, 1, 4'b1111, 3, 0, SWITCH);
      vadd(4'b0101, 1, 1, 4'b0111, 3, 1, GRANT);
      for (int k = 0; k < TMO; k++) vadd(4'b0101, 1, 1, 4'b0111, 3, 1, GRANT);
      vadd(4'b0101, 1, 1, 4'b1111, 1, 0, SWITCH);
      vadd(4'b0101, 1, 1, 4'b1101, 1, 1, GRANT);
      // device 1 starts a transaction; reset hits while it is OWNED
      vadd(4'b1101, 0, 0, 4'b1101, 1, 1, OWNED);
      split = vecs.size();
      // after reset: frame held low is ignored until the bus is seen idle
      vadd(4'b1111, 0, 0, 4'b1110, 0, 1, PARK);
      vadd(4'b1101, 0, 0, 4'b1111, 1, 0, SWITCH);
      vadd(4'b1101, 0, 0, 4'b1101, 1, 1, GRANT);
      vadd(4'b1101, 0, 0, 4'b1101, 1, 1, GRANT);
      vadd(4'b1101, 1, 1, 4'b1101, 1, 1, GRANT);
      vadd(4'b1101, 0, 0, 4'b1101, 1, 1, OWNED);
      vadd(4'b1111, 1, 1, 4'b1111, 0, 0, SWITCH);
      vadd(4'b1111, 1, 1, 4'b1110, 0, 1, PARK);

      // reset state
      rst       = 1'b1;
      bus.req   = 4'b1111;
      bus.frame = 1'b1;
      bus.irdy  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset", 4'b1111, owner_t'(PARK_M), 1'b0);
      n_vec++;
      if (bus.owner !== owner_t'(PARK_M)) begin
         n_err++;
         $display("FAIL reset_owner: owner=%0d, expected owner=%0d", bus.owner, PARK_M);
      end
      check_state("reset_state", SWITCH);
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < split; k++) apply(k);

      // asynchronous reset mid-transaction, between clock edges
      #2;
      bus.req   = 4'b1111;
      rst       = 1'b1;
      #1;
      check("async_reset", 4'b1111, owner_t'(PARK_M), 1'b0);
      check_state("async_reset_state", SWITCH);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("first_edge_after_reset", 4'b1110, owner_t'(PARK_M), 1'b1);

      for (int k = split; k < vecs.size(); k++) apply(k);

      // randomized traffic against the model
      @(negedge clk);
      rst       = 1'b1;
      bus.req   = 4'b1111;
      bus.frame = 1'b1;
      bus.irdy  = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
      r = 4'b1111;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(19) == 0) r[b[1:0]] = ~r[b[1:0]];
         end
         bus.req   = r;
         bus.frame = ($urandom_range(3) != 0);
         bus.irdy  = ($urandom_range(3) != 0);
         @(posedge clk);
         model_edge(bus.req, bus.frame, bus.irdy);
         exp_q.push_back(model_expect());
         #1;
         e = exp_q.pop_front();
         check($sformatf("rand%0d", c), e[6:3], e[2:1], e[0]);
         n_vec++;
         if ($countones(~bus.gnt) > 1) begin
            n_err++;
            $display("FAIL one_grant%0d: gnt=%b, expected at most one low bit", c, bus.gnt);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
